maze_game_ctl: RTL and testbench

Game sequencer for the LED-matrix maze. It sits between the keypad path and the maze datapath (position shifters, map ROM, collision latch). It qualifies decoded key codes into single-cycle move commands and selects the map level, which drives the map ROM address high bits. It also pulses a position/collision clear and tracks lives, level progress and move count, running the game through idle, play, hit, win and game-over phases.

---
 rtl/maze_game_ctl.sv | 174 +++++++++++++++++
 tb/tb_maze_game_ctl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_game_ctl.sv
// Maze game sequencer: key qualification, level select,
// lives / move tracking and idle-play-hit-win-over phases.
module maze_game_ctl #(
  parameter int LIVES = 3,
  parameter int NUM_LEVELS = 2,
  parameter int MOVE_GAP = 8,
  parameter int HOLD_CYCLES = 64,
  parameter logic [7:0] GOAL_HOR = 8'b0000_0001,
  parameter logic [7:0] GOAL_VER = 8'b1000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] keycode,
  input  logic       coll,
  input  logic [7:0] hor,
  input  logic [7:0] ver,
  output logic       mv_up,
  output logic       mv_down,
  output logic       mv_left,
  output logic       mv_right,
  output logic       pos_clr,
  output logic [1:0] level,
  output logic [1:0] lives,
  output logic [7:0] move_cnt,
  output logic [2:0] state,
  output logic       blink
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  localparam logic [1:0] LIVES_LD = 2'(LIVES);
  localparam logic [1:0] LAST_LVL = 2'(NUM_LEVELS - 1);
  localparam logic [7:0] GAP_LD   = 8'(MOVE_GAP);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

  logic [2:0] state_n;
  logic [1:0] level_n;
  logic [1:0] lives_n;
  logic [7:0] cnt_n;
  logic [7:0] gap, gap_n;
  logic [7:0] hold, hold_n;
  logic [3:0] mv_n;
  logic [3:0] dir;
  logic       clr_n;
  logic       blink_n;
  logic       start;
  logic       at_goal;

  assign start   = key_valid && (keycode == 4'd5);
  assign at_goal = (hor == GOAL_HOR) && (ver == GOAL_VER);

  // Map a keycode to a one-hot {up,down,left,right} direction
  always_comb begin
    dir = 4'b0000;
    case (keycode)
      4'd2:    dir = 4'b1000;
      4'd8:    dir = 4'b0100;
      4'd4:    dir = 4'b0010;
      4'd6:    dir = 4'b0001;
      default: dir = 4'b0000;
    endcase
  end

  // State and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      level    <= 2'd0;
      lives    <= LIVES_LD;
      move_cnt <= 8'd0;
      gap      <= 8'd0;
      hold     <= 8'd0;
      mv_up    <= 1'b0;
      mv_down  <= 1'b0;
      mv_left  <= 1'b0;
      mv_right <= 1'b0;
      pos_clr  <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      lives    <= lives_n;
      move_cnt <= cnt_n;
      gap      <= gap_n;
      hold     <= hold_n;
      mv_up    <= mv_n[3];
      mv_down  <= mv_n[2];
      mv_left  <= mv_n[1];
      mv_right <= mv_n[0];
      pos_clr  <= clr_n;
      blink    <= blink_n;
    end
  end

  // Next phase, counters and one-shot commands
  always_comb begin
    state_n = state;
    level_n = level;
    lives_n = lives;
    cnt_n   = move_cnt;
    mv_n    = 4'b0000;
    clr_n   = 1'b0;
    gap_n   = (gap != 8'd0) ? gap - 8'd1 : 8'd0;
    hold_n  = (hold != 8'd0) ? hold - 8'd1 : 8'd0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          clr_n   = 1'b1;
          cnt_n   = 8'd0;
          state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (coll) begin
          state_n = S_HIT;
          lives_n = lives - 2'd1;
          hold_n  = HOLD_LD;
        end else if (at_goal) begin
          state_n = S_WIN;
          hold_n  = HOLD_LD;
        end else if (key_valid && gap == 8'd0 && dir != 4'b0000) begin
          mv_n  = dir;
          cnt_n = (move_cnt == 8'hFF) ? move_cnt : move_cnt + 8'd1;
          gap_n = GAP_LD;
        end
      end
      S_HIT: begin
        if (hold == 8'd0) begin
          if (lives == 2'd0) begin
            state_n = S_OVER;
          end else begin
            clr_n   = 1'b1;
            cnt_n   = 8'd0;
            state_n = S_PLAY;
          end
        end
      end
      S_WIN: begin
        if (hold == 8'd0) begin
          if (level < LAST_LVL) begin
            level_n = level + 2'd1;
            clr_n   = 1'b1;
            cnt_n   = 8'd0;
            state_n = S_PLAY;
          end else if (start) begin
            level_n = 2'd0;
            lives_n = LIVES_LD;
            state_n = S_IDLE;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          level_n = 2'd0;
          lives_n = LIVES_LD;
          cnt_n   = 8'd0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Display flash follows the phase being entered
  always_comb begin
    blink_n = (state_n == S_HIT) || (state_n == S_WIN);
  end

endmodule

// File: tb/tb_maze_game_ctl.sv
// Bench for maze_game_ctl: directed table, corner sequences
// and random stimulus against a cycle-count reference model.
module tb_maze_game_ctl;

  localparam int LIVES = 3;
  localparam int NUM_LEVELS = 2;
  localparam int MOVE_GAP = 8;
  localparam int HOLD = 64;
  localparam logic [7:0] GH = 8'b0000_0001;
  localparam logic [7:0] GV = 8'b1000_0000;
  localparam logic [7:0] OH = 8'b0001_0000;
  localparam logic [7:0] OV = 8'b0000_1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] keycode = 4'd0;
  logic       coll = 1'b0;
  logic [7:0] hor = OH;
  logic [7:0] ver = OV;
  logic       mv_up, mv_down, mv_left, mv_right;
  logic       pos_clr, blink;
  logic [1:0] level, lives;
  logic [7:0] move_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  maze_game_ctl #(
    .LIVES(LIVES), .NUM_LEVELS(NUM_LEVELS), .MOVE_GAP(MOVE_GAP),
    .HOLD_CYCLES(HOLD), .GOAL_HOR(GH), .GOAL_VER(GV)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid),
    .keycode(keycode), .coll(coll), .hor(hor), .ver(ver),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left),
    .mv_right(mv_right), .pos_clr(pos_clr), .level(level),
    .lives(lives), .move_cnt(move_cnt), .state(state),
    .blink(blink)
  );

  always #5 clk = ~clk;

  // Reference model: phases as numbers, timers as cycle stamps
  int m_ph, m_lvl, m_lives, m_mc, m_enter, m_last, m_n;
  logic [3:0] m_mv;
  logic m_pc;

  function automatic logic [3:0] key_dir(input logic [3:0] kc);
    if (kc == 4'd2) return 4'b1000;
    if (kc == 4'd8) return 4'b0100;
    if (kc == 4'd4) return 4'b0010;
    if (kc == 4'd6) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_lvl = 0; m_lives = LIVES; m_mc = 0;
    m_enter = 0; m_last = -100; m_n = 0; m_mv = 0; m_pc = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc,
                            input logic cl, input logic [7:0] h,
                            input logic [7:0] v);
    logic st;
    st = kv && kc == 4'd5;
    m_n++;
    m_mv = 0;
    m_pc = 0;
    case (m_ph)
      0: if (st) begin m_pc = 1; m_mc = 0; m_ph = 1; end
      1: begin
        if (cl) begin
          m_ph = 2; m_lives--; m_enter = m_n;
        end else if (h == GH && v == GV) begin
          m_ph = 3; m_enter = m_n;
        end else if (kv && key_dir(kc) != 0 && m_n - m_last > MOVE_GAP) begin
          m_mv = key_dir(kc);
          m_mc = (m_mc < 255) ? m_mc + 1 : 255;
          m_last = m_n;
        end
      end
      2: if (m_n - m_enter == HOLD) begin
        if (m_lives == 0) m_ph = 4;
        else begin m_pc = 1; m_mc = 0; m_ph = 1; end
      end
      3: if (m_n - m_enter >= HOLD) begin
        if (m_lvl < NUM_LEVELS - 1) begin
          m_lvl++; m_pc = 1; m_mc = 0; m_ph = 1;
        end else if (st) begin
          m_lvl = 0; m_lives = LIVES; m_ph = 0;
        end
      end
      4: if (st) begin
        m_lvl = 0; m_lives = LIVES; m_mc = 0; m_ph = 0;
      end
      default: m_ph = 0;
    endcase
  endtask

  function automatic logic [31:0] exp_vec();
    logic bl;
    bl = (m_ph == 2) || (m_ph == 3);
    return {11'd0, 3'(m_ph), 2'(m_lvl), 2'(m_lives), 8'(m_mc),
            m_mv, m_pc, bl};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {11'd0, state, level, lives, move_cnt,
            mv_up, mv_down, mv_left, mv_right, pos_clr, blink};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kc,
                      input logic cl, input logic [7:0] h,
                      input logic [7:0] v);
    key_valid = kv; keycode = kc; coll = cl; hor = h; ver = v;
    @(posedge clk);
    model_step(kv, kc, cl, h, v);
    @(negedge clk);
    chk("model", dut_vec(), exp_vec());
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(0, 4'd0, 0, OH, OV);
  endtask

  task automatic key(input logic [3:0] kc);
    step(1, kc, 0, OH, OV);
  endtask

  task automatic goal();
    step(0, 4'd0, 0, GH, GV);
  endtask

  // {state, level, lives, move_cnt, pos_clr, blink}
  function automatic logic [31:0] sv(input logic [2:0] s,
      input logic [1:0] l, input logic [1:0] lv, input logic [7:0] mc,
      input logic pc, input logic bl);
    return {15'd0, s, l, lv, mc, pc, bl};
  endfunction

  function automatic logic [31:0] dsv();
    return {15'd0, state, level, lives, move_cnt, pos_clr, blink};
  endfunction

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       cl;
    logic       gl;
    logic [2:0] st;
    logic [3:0] mv;
    logic       pc;
    logic [7:0] mc;
    logic [1:0] lv;
    logic       bl;
  } vec_t;

  function automatic vec_t mk(input logic kv, input logic [3:0] kc,
      input logic cl, input logic gl, input logic [2:0] st,
      input logic [3:0] mv, input logic pc, input logic [7:0] mc,
      input logic [1:0] lv, input logic bl);
    vec_t r;
    r.kv = kv; r.kc = kc; r.cl = cl; r.gl = gl; r.st = st;
    r.mv = mv; r.pc = pc; r.mc = mc; r.lv = lv; r.bl = bl;
    return r;
  endfunction

  vec_t tbl[16];
  logic [3:0] kcs[8];

  initial begin
    tbl[0]  = mk(1, 5, 0, 0, 1, 4'b0000, 1, 0, 3, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 4'b0000, 0, 0, 3, 0);
    tbl[2]  = mk(1, 6, 0, 0, 1, 4'b0001, 0, 1, 3, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 4'b0000, 0, 1, 3, 0);
    tbl[4]  = mk(1, 6, 0, 0, 1, 4'b0000, 0, 1, 3, 0);
    tbl[5]  = mk(1, 2, 0, 0, 1, 4'b0000, 0, 1, 3, 0);
    for (int i = 6; i < 11; i++)
      tbl[i] = mk(0, 0, 0, 0, 1, 4'b0000, 0, 1, 3, 0);
    tbl[11] = mk(1, 8, 0, 0, 1, 4'b0100, 0, 2, 3, 0);
    tbl[12] = mk(1, 5, 0, 0, 1, 4'b0000, 0, 2, 3, 0);
    tbl[13] = mk(1, 0, 0, 0, 1, 4'b0000, 0, 2, 3, 0);
    tbl[14] = mk(1, 4, 1, 0, 2, 4'b0000, 0, 2, 2, 1);
    tbl[15] = mk(0, 0, 0, 0, 2, 4'b0000, 0, 2, 2, 1);
    kcs[0] = 4'd0; kcs[1] = 4'd2; kcs[2] = 4'd4; kcs[3] = 4'd5;
    kcs[4] = 4'd6; kcs[5] = 4'd8; kcs[6] = 4'd1; kcs[7] = 4'd15;

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset", dsv(), sv(0, 0, 3, 0, 0, 0));
    reset = 1'b1;
    idle(1);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].kv, tbl[i].kc, tbl[i].cl,
           tbl[i].gl ? GH : OH, tbl[i].gl ? GV : OV);
      chk($sformatf("tbl%0d", i), dut_vec(),
          {11'd0, tbl[i].st, 2'd0, tbl[i].lv, tbl[i].mc,
           tbl[i].mv, tbl[i].pc, tbl[i].bl});
    end

    idle(62);
    chk("hit_hold", dsv(), sv(2, 0, 2, 2, 0, 1));
    idle(1);
    chk("hit_exit", dsv(), sv(1, 0, 2, 0, 1, 0));
    step(1, 4'd6, 1, OH, OV);
    chk("hit2", dsv(), sv(2, 0, 1, 0, 0, 1));
    idle(64);
    chk("hit2_exit", dsv(), sv(1, 0, 1, 0, 1, 0));
    step(0, 4'd0, 1, OH, OV);
    chk("hit3", dsv(), sv(2, 0, 0, 0, 0, 1));
    idle(64);
    chk("over", dsv(), sv(4, 0, 0, 0, 0, 0));
    key(4'd5);
    chk("over_exit", dsv(), sv(0, 0, 3, 0, 0, 0));

    key(4'd5);
    goal();
    chk("win0", dsv(), sv(3, 0, 3, 0, 0, 1));
    idle(64);
    chk("win0_exit", dsv(), sv(1, 1, 3, 0, 1, 0));
    goal();
    chk("win1", dsv(), sv(3, 1, 3, 0, 0, 1));
    idle(70);
    chk("win1_stay", dsv(), sv(3, 1, 3, 0, 0, 1));
    key(4'd5);
    chk("win1_exit", dsv(), sv(0, 0, 3, 0, 0, 0));

    key(4'd5);
    step(1, 4'd2, 1, GH, GV);
    chk("coll_prio", dsv(), sv(2, 0, 2, 0, 0, 1));
    idle(10);
    reset = 1'b0;
    #1;
    chk("async_rst", dsv(), sv(0, 0, 3, 0, 0, 0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    chk("rst_release", dsv(), sv(0, 0, 3, 0, 0, 0));

    key(4'd5);
    for (int i = 0; i < 300; i++) begin
      key(kcs[1 + (i % 2) * 3]);
      idle(MOVE_GAP);
    end
    chk("sat", 32'(move_cnt), 32'd255);

    for (int i = 0; i < 4000; i++) begin
      logic kv, cl, gl;
      logic [7:0] h, v;
      if ($urandom_range(0, 999) == 0) begin
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rnd_rst", dut_vec(), exp_vec());
        @(negedge clk);
        reset = 1'b1;
      end
      kv = ($urandom_range(0, 99) < 35);
      cl = ($urandom_range(0, 59) == 0);
      gl = ($urandom_range(0, 49) == 0);
      h = gl ? GH : 8'(1 << $urandom_range(0, 7));
      v = gl ? GV : 8'(1 << $urandom_range(0, 7));
      step(kv, kcs[$urandom_range(0, 7)], cl, h, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
